// File: rtl/dram_line_adapter_pkg.sv
// Shared types and constants for the two-client cacheline adapter in front of the DRAM burst port.
// The line is split into BURST_LEN beats of BEAT_W bits each.
package dram_adapter_pkg;

   localparam int ADDR_W     = 32;
   localparam int BEAT_W     = 64;
   localparam int BURST_LEN  = 4;
   localparam int LINE_W     = BEAT_W * BURST_LEN;
   localparam int BEAT_CNT_W = $clog2(BURST_LEN);
   localparam int N_CLIENTS  = 2;

   typedef logic client_id_t;
   typedef logic [BEAT_CNT_W-1:0] beat_idx_t;

   localparam beat_idx_t LAST_BEAT = beat_idx_t'(BURST_LEN - 1);

   // age=1 marks the older of two outstanding reads
   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] addr;
      logic              age;
   } ost_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      RD_CMD,
      WR_BURST
   } issue_state_e;

   function automatic logic [BEAT_W-1:0] line_beat(input logic [LINE_W-1:0] line,
                                                   input beat_idx_t         idx);
      return line[int'(idx)*BEAT_W +: BEAT_W];
   endfunction

endpackage

// File: rtl/dram_line_adapter_line_deserializer.sv
// Collects a back-to-back read burst into one cacheline.
// done_o is combinational on the final beat so the response can be registered the cycle after.
module line_deserializer
   import dram_adapter_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              m_rvalid_i,
   input  logic [BEAT_W-1:0] m_rdata_i,
   input  logic [ADDR_W-1:0] m_raddr_i,
   output logic              done_o,
   output logic [ADDR_W-1:0] raddr_o,
   output logic [LINE_W-1:0] line_o
);

   beat_idx_t         cnt_q, cnt_d;
   logic [ADDR_W-1:0] raddr_q;
   logic [BEAT_W-1:0] buf_q [BURST_LEN-1];

   always_comb begin
      cnt_d = '0;
      if (m_rvalid_i) begin
         cnt_d = (cnt_q == LAST_BEAT) ? '0 : beat_idx_t'(cnt_q + 1'b1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         raddr_q <= '0;
         for (int k = 0; k < BURST_LEN-1; k++) begin
            buf_q[k] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
         if (m_rvalid_i && cnt_q == '0) begin
            raddr_q <= m_raddr_i;
         end
         for (int k = 0; k < BURST_LEN-1; k++) begin
            if (m_rvalid_i && cnt_q == beat_idx_t'(k)) begin
               buf_q[k] <= m_rdata_i;
            end
         end
      end
   end

   // The last beat bypasses the buffer and goes straight into the line.
   always_comb begin
      line_o = '0;
      for (int k = 0; k < BURST_LEN-1; k++) begin
         line_o[k*BEAT_W +: BEAT_W] = buf_q[k];
      end
      line_o[LINE_W-1 -: BEAT_W] = m_rdata_i;
   end

   assign done_o  = m_rvalid_i && (cnt_q == LAST_BEAT);
   assign raddr_o = raddr_q;

   a_no_gap: assert property (@(posedge clk) disable iff (!rst_n) (cnt_q != '0) |-> m_rvalid_i);

endmodule

// File: rtl/dram_line_adapter.sv
// Arbitrates icache/dcache line requests onto a 64-bit DRAM burst port.
// Writes are serialised into 4-beat bursts; read bursts are reassembled and routed by address.
module dram_line_adapter
   import dram_adapter_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [ADDR_W-1:0]    c_addr_i  [N_CLIENTS],
   input  logic [N_CLIENTS-1:0] c_read_i,
   input  logic [N_CLIENTS-1:0] c_write_i,
   input  logic [LINE_W-1:0]    c_wdata_i [N_CLIENTS],
   output logic [LINE_W-1:0]    c_rdata_o [N_CLIENTS],
   output logic [N_CLIENTS-1:0] c_resp_o,
   output logic [ADDR_W-1:0]    m_addr_o,
   output logic                 m_read_o,
   output logic                 m_write_o,
   output logic [BEAT_W-1:0]    m_wdata_o,
   input  logic                 m_ready_i,
   input  logic [ADDR_W-1:0]    m_raddr_i,
   input  logic [BEAT_W-1:0]    m_rdata_i,
   input  logic                 m_rvalid_i
);

   issue_state_e         state_q, state_d;
   client_id_t           gnt_q, gnt_d, rr_q, rr_d, pick, win;
   beat_idx_t            beat_q, beat_d;
   logic [ADDR_W-1:0]    m_addr_q, m_addr_d;
   logic                 m_read_q, m_read_d, m_write_q, m_write_d, grant, rec;
   logic [BEAT_W-1:0]    m_wdata_q, m_wdata_d;
   logic [N_CLIENTS-1:0] wr_resp_q, wr_resp_d, rd_resp_q, rd_resp_d, eligible, match;
   ost_entry_t           ost_q [N_CLIENTS];
   ost_entry_t           ost_d [N_CLIENTS];
   logic [LINE_W-1:0]    rdata_q [N_CLIENTS];
   logic [LINE_W-1:0]    rdata_d [N_CLIENTS];
   logic                 rd_done;
   logic [ADDR_W-1:0]    rd_addr;
   logic [LINE_W-1:0]    rd_line;

   line_deserializer u_deser (
      .clk        (clk),
      .rst_n      (rst_n),
      .m_rvalid_i (m_rvalid_i),
      .m_rdata_i  (m_rdata_i),
      .m_raddr_i  (m_raddr_i),
      .done_o     (rd_done),
      .raddr_o    (rd_addr),
      .line_o     (rd_line)
   );

   assign rec = (state_q == RD_CMD) && m_ready_i;

   // A client whose response is on the wire this cycle still holds its request, so it is masked.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      rr_d      = rr_q;
      beat_d    = beat_q;
      m_addr_d  = m_addr_q;
      m_read_d  = m_read_q;
      m_write_d = m_write_q;
      m_wdata_d = m_wdata_q;
      wr_resp_d = '0;
      grant     = 1'b0;
      pick      = rr_q;
      for (int c = 0; c < N_CLIENTS; c++) begin
         eligible[c] = (c_read_i[c] | c_write_i[c]) & ~ost_q[c].valid & ~c_resp_o[c];
      end
      case (state_q)
         IDLE: begin
            m_read_d  = 1'b0;
            m_write_d = 1'b0;
            if (eligible[rr_q]) begin
               grant = 1'b1;
               pick  = rr_q;
            end else if (eligible[~rr_q]) begin
               grant = 1'b1;
               pick  = ~rr_q;
            end
            if (grant) begin
               gnt_d    = pick;
               rr_d     = ~pick;
               beat_d   = '0;
               m_addr_d = c_addr_i[pick];
               if (c_write_i[pick]) begin
                  state_d   = WR_BURST;
                  m_write_d = 1'b1;
                  m_wdata_d = line_beat(c_wdata_i[pick], '0);
               end else begin
                  state_d  = RD_CMD;
                  m_read_d = 1'b1;
               end
            end
         end
         RD_CMD: begin
            if (m_ready_i) begin
               m_read_d = 1'b0;
               state_d  = IDLE;
            end
         end
         WR_BURST: begin
            if (m_ready_i) begin
               m_write_d = 1'b0;
               if (beat_q == LAST_BEAT) begin
                  wr_resp_d[gnt_q] = 1'b1;
                  state_d          = IDLE;
               end else begin
                  beat_d    = beat_idx_t'(beat_q + 1'b1);
                  m_wdata_d = line_beat(c_wdata_i[gnt_q], beat_idx_t'(beat_q + 1'b1));
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // When both entries hold the returned address, the older one owns this burst.
   always_comb begin
      ost_d     = ost_q;
      rdata_d   = rdata_q;
      rd_resp_d = '0;
      for (int c = 0; c < N_CLIENTS; c++) begin
         match[c] = ost_q[c].valid && (ost_q[c].addr == rd_addr);
      end
      win = match[0] ? (match[1] ? ~ost_q[0].age : 1'b0) : 1'b1;
      if (rd_done && |match) begin
         rd_resp_d[win]    = 1'b1;
         rdata_d[win]      = rd_line;
         ost_d[win].valid  = 1'b0;
      end
      if (rec) begin
         ost_d[gnt_q].valid = 1'b1;
         ost_d[gnt_q].addr  = m_addr_q;
         ost_d[gnt_q].age   = 1'b0;
         if (ost_d[~gnt_q].valid) begin
            ost_d[~gnt_q].age = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= 1'b0;
         rr_q      <= 1'b1;
         beat_q    <= '0;
         m_addr_q  <= '0;
         m_read_q  <= 1'b0;
         m_write_q <= 1'b0;
         m_wdata_q <= '0;
         wr_resp_q <= '0;
         rd_resp_q <= '0;
         for (int c = 0; c < N_CLIENTS; c++) begin
            ost_q[c]   <= '0;
            rdata_q[c] <= '0;
         end
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         rr_q      <= rr_d;
         beat_q    <= beat_d;
         m_addr_q  <= m_addr_d;
         m_read_q  <= m_read_d;
         m_write_q <= m_write_d;
         m_wdata_q <= m_wdata_d;
         wr_resp_q <= wr_resp_d;
         rd_resp_q <= rd_resp_d;
         ost_q     <= ost_d;
         rdata_q   <= rdata_d;
      end
   end

   assign m_addr_o  = m_addr_q;
   assign m_read_o  = m_read_q;
   assign m_write_o = m_write_q;
   assign m_wdata_o = m_wdata_q;
   assign c_resp_o  = wr_resp_q | rd_resp_q;
   assign c_rdata_o = rdata_q;

   a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n) (c_read_i & c_write_i) == '0);
   a_ret_matches:  assert property (@(posedge clk) disable iff (!rst_n) rd_done |-> (|match));

endmodule

// File: tb/tb_dram_line_adapter.sv
// Directed scenario bench for dram_line_adapter; each task drives one scenario and checks inline.
// Memory responses are driven by hand so every expected beat and pulse is fixed in the task.
module tb_dram_line_adapter;

   logic         clk;
   logic         rst_n;
   logic [31:0]  c_addr  [2];
   logic [1:0]   c_read;
   logic [1:0]   c_write;
   logic [255:0] c_wdata [2];
   logic [255:0] c_rdata [2];
   logic [1:0]   c_resp;
   logic [31:0]  m_addr;
   logic         m_read;
   logic         m_write;
   logic [63:0]  m_wdata;
   logic         m_ready;
   logic [31:0]  m_raddr;
   logic [63:0]  m_rdata;
   logic         m_rvalid;

   int errors = 0;
   int checks = 0;

   dram_line_adapter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .c_addr_i  (c_addr),
      .c_read_i  (c_read),
      .c_write_i (c_write),
      .c_wdata_i (c_wdata),
      .c_rdata_o (c_rdata),
      .c_resp_o  (c_resp),
      .m_addr_o  (m_addr),
      .m_read_o  (m_read),
      .m_write_o (m_write),
      .m_wdata_o (m_wdata),
      .m_ready_i (m_ready),
      .m_raddr_i (m_raddr),
      .m_rdata_i (m_rdata),
      .m_rvalid_i(m_rvalid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      c_read = '0; c_write = '0; m_ready = 1'b0; m_rvalid = 1'b0;
      m_raddr = '0; m_rdata = '0;
      c_addr[0] = '0; c_addr[1] = '0; c_wdata[0] = '0; c_wdata[1] = '0;
      rst_n = 1'b0;
      step();
      step();
      checks++; if (m_read !== 1'b0) begin errors++; $display("[TB] FAIL reset m_read got=%b exp=0", m_read); end
      checks++; if (m_write !== 1'b0) begin errors++; $display("[TB] FAIL reset m_write got=%b exp=0", m_write); end
      checks++; if (m_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset m_addr got=%h exp=0", m_addr); end
      checks++; if (m_wdata !== 64'h0) begin errors++; $display("[TB] FAIL reset m_wdata got=%h exp=0", m_wdata); end
      checks++; if (c_resp !== 2'b00) begin errors++; $display("[TB] FAIL reset c_resp got=%b exp=00", c_resp); end
      checks++; if (c_rdata[0] !== 256'h0 || c_rdata[1] !== 256'h0) begin errors++; $display("[TB] FAIL reset c_rdata got=%h/%h exp=0", c_rdata[0], c_rdata[1]); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_icache_read();
      logic [63:0]  beats [4];
      logic [255:0] exp_line;
      int           acc;
      beats[0] = {4{16'h1111}}; beats[1] = {4{16'h2222}};
      beats[2] = {4{16'h3333}}; beats[3] = {4{16'h4444}};
      exp_line = {beats[3], beats[2], beats[1], beats[0]};
      acc = 0;
      c_addr[0] = 32'h0000_1000; c_read[0] = 1'b1; m_ready = 1'b0;
      step();
      checks++; if (m_read !== 1'b1 || m_addr !== 32'h0000_1000) begin errors++; $display("[TB] FAIL rd_issue m_read/m_addr got=%b/%h exp=1/00001000", m_read, m_addr); end
      step();
      checks++; if (m_read !== 1'b1) begin errors++; $display("[TB] FAIL rd_stall_hold m_read got=%b exp=1", m_read); end
      m_ready = 1'b1;
      if (m_read && m_ready) acc++;
      step();
      m_ready = 1'b0;
      checks++; if (m_read !== 1'b0) begin errors++; $display("[TB] FAIL rd_drop m_read got=%b exp=0", m_read); end
      for (int k = 0; k < 4; k++) begin
         m_rvalid = 1'b1; m_raddr = 32'h0000_1000; m_rdata = beats[k];
         if (m_read && m_ready) acc++;
         checks++; if (c_resp !== 2'b00 || m_read !== 1'b0) begin errors++; $display("[TB] FAIL rd_wait beat%0d c_resp/m_read got=%b/%b exp=00/0", k, c_resp, m_read); end
         step();
      end
      m_rvalid = 1'b0;
      checks++; if (c_resp !== 2'b01) begin errors++; $display("[TB] FAIL rd_resp c_resp got=%b exp=01", c_resp); end
      checks++; if (c_rdata[0] !== exp_line) begin errors++; $display("[TB] FAIL rd_data got=%h exp=%h", c_rdata[0], exp_line); end
      c_read[0] = 1'b0;
      step();
      checks++; if (c_resp !== 2'b00) begin errors++; $display("[TB] FAIL rd_resp_once c_resp got=%b exp=00", c_resp); end
      checks++; if (acc !== 1) begin errors++; $display("[TB] FAIL rd_accept_count got=%0d exp=1", acc); end
   endtask

   task automatic test_write_stall();
      logic [63:0] w [4];
      w[0] = {4{16'hA0A0}}; w[1] = {4{16'hB1B1}}; w[2] = {4{16'hC2C2}}; w[3] = {4{16'hD3D3}};
      c_addr[1] = 32'h0000_2040; c_wdata[1] = {w[3], w[2], w[1], w[0]}; c_write[1] = 1'b1; m_ready = 1'b1;
      step();
      checks++; if (m_write !== 1'b1 || m_wdata !== w[0] || m_addr !== 32'h0000_2040) begin errors++; $display("[TB] FAIL wr_beat0 m_write/m_wdata/m_addr got=%b/%h/%h exp=1/%h/00002040", m_write, m_wdata, m_addr, w[0]); end
      step();
      checks++; if (m_write !== 1'b0 || m_wdata !== w[1]) begin errors++; $display("[TB] FAIL wr_beat1 m_write/m_wdata got=%b/%h exp=0/%h", m_write, m_wdata, w[1]); end
      step();
      m_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         checks++; if (m_write !== 1'b0 || m_wdata !== w[2] || m_addr !== 32'h0000_2040) begin errors++; $display("[TB] FAIL wr_stall%0d m_write/m_wdata got=%b/%h exp=0/%h", s, m_write, m_wdata, w[2]); end
         step();
      end
      checks++; if (m_wdata !== w[2]) begin errors++; $display("[TB] FAIL wr_stall_end m_wdata got=%h exp=%h", m_wdata, w[2]); end
      m_ready = 1'b1;
      step();
      checks++; if (m_write !== 1'b0 || m_wdata !== w[3] || c_resp !== 2'b00) begin errors++; $display("[TB] FAIL wr_beat3 m_write/m_wdata/c_resp got=%b/%h/%b exp=0/%h/00", m_write, m_wdata, c_resp, w[3]); end
      step();
      checks++; if (c_resp !== 2'b10 || m_write !== 1'b0) begin errors++; $display("[TB] FAIL wr_resp c_resp/m_write got=%b/%b exp=10/0", c_resp, m_write); end
      c_write[1] = 1'b0; m_ready = 1'b0;
      step();
      checks++; if (c_resp !== 2'b00 || m_write !== 1'b0) begin errors++; $display("[TB] FAIL wr_resp_once c_resp/m_write got=%b/%b exp=00/0", c_resp, m_write); end
   endtask

   task automatic test_both_clients();
      logic [63:0] p [4];
      logic [63:0] q [4];
      for (int k = 0; k < 4; k++) begin
         p[k] = 64'h0101_0000_0000_0000 + 64'(k);
         q[k] = 64'h0202_0000_0000_0000 + 64'(k);
      end
      do_reset();
      c_addr[0] = 32'h0000_4000; c_addr[1] = 32'h0000_5000; c_read = 2'b11; m_ready = 1'b1;
      step();
      checks++; if (m_read !== 1'b1 || m_addr !== 32'h0000_5000) begin errors++; $display("[TB] FAIL rr_first m_read/m_addr got=%b/%h exp=1/00005000", m_read, m_addr); end
      step();
      checks++; if (m_read !== 1'b0) begin errors++; $display("[TB] FAIL rr_gap m_read got=%b exp=0", m_read); end
      step();
      checks++; if (m_read !== 1'b1 || m_addr !== 32'h0000_4000) begin errors++; $display("[TB] FAIL rr_second m_read/m_addr got=%b/%h exp=1/00004000", m_read, m_addr); end
      step();
      m_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         m_rvalid = 1'b1; m_raddr = 32'h0000_4000; m_rdata = p[k];
         step();
      end
      checks++; if (c_resp !== 2'b01 || c_rdata[0] !== {p[3], p[2], p[1], p[0]}) begin errors++; $display("[TB] FAIL rev_icache c_resp/c_rdata0 got=%b/%h", c_resp, c_rdata[0]); end
      c_read[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         m_rvalid = 1'b1; m_raddr = 32'h0000_5000; m_rdata = q[k];
         step();
      end
      m_rvalid = 1'b0;
      checks++; if (c_resp !== 2'b10 || c_rdata[1] !== {q[3], q[2], q[1], q[0]}) begin errors++; $display("[TB] FAIL rev_dcache c_resp/c_rdata1 got=%b/%h", c_resp, c_rdata[1]); end
      c_read[1] = 1'b0;
      step();
   endtask

   task automatic test_same_addr();
      logic [63:0] r [4];
      logic [63:0] s [4];
      for (int k = 0; k < 4; k++) begin
         r[k] = 64'hAAAA_0000_0000_0000 + 64'(k);
         s[k] = 64'h5555_0000_0000_0000 + 64'(k);
      end
      c_addr[0] = 32'h0000_3000; c_addr[1] = 32'h0000_3000; c_read[0] = 1'b1; m_ready = 1'b1;
      step();
      c_read[1] = 1'b1;
      checks++; if (m_read !== 1'b1 || m_addr !== 32'h0000_3000) begin errors++; $display("[TB] FAIL same_first m_read/m_addr got=%b/%h exp=1/00003000", m_read, m_addr); end
      step();
      step();
      checks++; if (m_read !== 1'b1) begin errors++; $display("[TB] FAIL same_second m_read got=%b exp=1", m_read); end
      step();
      m_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         m_rvalid = 1'b1; m_raddr = 32'h0000_3000; m_rdata = r[k];
         step();
      end
      checks++; if (c_resp !== 2'b01 || c_rdata[0] !== {r[3], r[2], r[1], r[0]}) begin errors++; $display("[TB] FAIL same_older c_resp/c_rdata0 got=%b/%h", c_resp, c_rdata[0]); end
      c_read[0] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         m_rvalid = 1'b1; m_raddr = 32'h0000_3000; m_rdata = s[k];
         step();
      end
      m_rvalid = 1'b0;
      checks++; if (c_resp !== 2'b10 || c_rdata[1] !== {s[3], s[2], s[1], s[0]}) begin errors++; $display("[TB] FAIL same_newer c_resp/c_rdata1 got=%b/%h", c_resp, c_rdata[1]); end
      c_read[1] = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_burst();
      logic [63:0] v [4];
      for (int k = 0; k < 4; k++) v[k] = 64'h6060_6060_0000_0000 + 64'(k);
      c_addr[0] = 32'h0000_6000; c_wdata[0] = {v[3], v[2], v[1], v[0]}; c_write[0] = 1'b1; m_ready = 1'b1;
      step();
      step();
      step();
      checks++; if (m_wdata !== v[2]) begin errors++; $display("[TB] FAIL rst_pre_beat2 m_wdata got=%h exp=%h", m_wdata, v[2]); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (m_write !== 1'b0 || m_read !== 1'b0 || c_resp !== 2'b00 || m_wdata !== 64'h0) begin errors++; $display("[TB] FAIL rst_async m_write/m_read/c_resp/m_wdata got=%b/%b/%b/%h exp=0/0/00/0", m_write, m_read, c_resp, m_wdata); end
      step();
      rst_n = 1'b1;
      step();
      checks++; if (m_write !== 1'b1 || m_wdata !== v[0] || m_addr !== 32'h0000_6000) begin errors++; $display("[TB] FAIL rst_reissue m_write/m_wdata/m_addr got=%b/%h/%h exp=1/%h/00006000", m_write, m_wdata, m_addr, v[0]); end
      step();
      step();
      step();
      checks++; if (m_wdata !== v[3] || c_resp !== 2'b00) begin errors++; $display("[TB] FAIL rst_beat3 m_wdata/c_resp got=%h/%b exp=%h/00", m_wdata, c_resp, v[3]); end
      step();
      checks++; if (c_resp !== 2'b01) begin errors++; $display("[TB] FAIL rst_resp c_resp got=%b exp=01", c_resp); end
      c_write[0] = 1'b0; m_ready = 1'b0;
      step();
   endtask

   task automatic test_concurrent_resp();
      logic [63:0] t [4];
      logic [63:0] u [4];
      for (int k = 0; k < 4; k++) begin
         t[k] = 64'h7070_0000_0000_0000 + 64'(k);
         u[k] = 64'h8080_0000_0000_0000 + 64'(k);
      end
      c_addr[1] = 32'h0000_7000; c_read[1] = 1'b1; m_ready = 1'b1;
      step();
      checks++; if (m_read !== 1'b1 || m_addr !== 32'h0000_7000) begin errors++; $display("[TB] FAIL conc_rd m_read/m_addr got=%b/%h exp=1/00007000", m_read, m_addr); end
      step();
      c_addr[0] = 32'h0000_8000; c_wdata[0] = {u[3], u[2], u[1], u[0]}; c_write[0] = 1'b1;
      step();
      checks++; if (m_write !== 1'b1 || m_wdata !== u[0]) begin errors++; $display("[TB] FAIL conc_wr0 m_write/m_wdata got=%b/%h exp=1/%h", m_write, m_wdata, u[0]); end
      for (int k = 0; k < 4; k++) begin
         m_rvalid = 1'b1; m_raddr = 32'h0000_7000; m_rdata = t[k];
         step();
         if (k < 3) begin
            checks++; if (m_wdata !== u[k+1] || c_resp !== 2'b00) begin errors++; $display("[TB] FAIL conc_beat%0d m_wdata/c_resp got=%h/%b exp=%h/00", k+1, m_wdata, c_resp, u[k+1]); end
         end
      end
      m_rvalid = 1'b0;
      checks++; if (c_resp !== 2'b11) begin errors++; $display("[TB] FAIL conc_both c_resp got=%b exp=11", c_resp); end
      checks++; if (c_rdata[1] !== {t[3], t[2], t[1], t[0]}) begin errors++; $display("[TB] FAIL conc_data c_rdata1 got=%h exp=%h", c_rdata[1], {t[3], t[2], t[1], t[0]}); end
      c_read = '0; c_write = '0; m_ready = 1'b0;
      step();
      checks++; if (c_resp !== 2'b00) begin errors++; $display("[TB] FAIL conc_after c_resp got=%b exp=00", c_resp); end
   endtask

   initial begin
      test_reset();
      test_icache_read();
      test_write_stall();
      test_both_clients();
      test_same_addr();
      test_reset_mid_burst();
      test_concurrent_resp();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dram_line_adapter.md
Name: dram_line_adapter

Overview:
- Sits directly upstream of the banked DRAM model, between the two L1 caches (instruction and data) and the memory's 64-bit burst port.
- Arbitrates whole 256-bit cacheline requests from the two clients and serialises each write into a 4-beat burst.
- Issues reads as single-cycle commands, reassembles returning 4-beat read bursts, and routes each completed line to the requesting client by matching the returned address.

Parameters:
- ADDR_W, 32, byte address width on all ports.
- BEAT_W, 64, memory bus width in bits.
- BURST_LEN, 4, beats per cacheline; line width = BEAT_W*BURST_LEN = 256.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- c_addr[2]  in  2xADDR_W  client line address (index 0 = icache, 1 = dcache); 32-byte aligned.
- c_read[2]  in  2x1  client read request, held until c_resp.
- c_write[2]  in  2x1  client write request, held until c_resp.
- c_wdata[2]  in  2x256  client write line.
- c_rdata[2]  out  2x256  returned line, valid when c_resp is high.
- c_resp[2]  out  2x1  one-cycle completion pulse.
- m_addr  out  ADDR_W  memory address.
- m_read  out  1  memory read command.
- m_write  out  1  memory write command, first beat only.
- m_wdata  out  BEAT_W  write beat.
- m_ready  in  1  memory accepts a command or beat this edge.
- m_raddr  in  ADDR_W  address of the returning read burst.
- m_rdata  in  BEAT_W  read beat.
- m_rvalid  in  1  read beat valid.

Behaviour:
- Reset (async, rst_n=0): m_read=m_write=0, m_addr=0, m_wdata=0, c_resp=0, c_rdata=0. FSM goes to IDLE, beat counters 0, outstanding table cleared, RR pointer to client 1. Any in-flight burst is abandoned.
- Client contract: at most one outstanding request per client; c_read and c_write both high is illegal (assertion). Inputs are held until c_resp.
- Issue FSM states: IDLE, RD_CMD, WR_BURST.
- IDLE:
  - Eligible client = request high and not already issued.
  - Round-robin grant; the pointer moves to the other client after each grant.
  - Registered: a grant in cycle N drives the memory outputs from cycle N+1.
- RD_CMD: drive m_read=1, m_addr = client addr. On an edge with m_ready=1, record an outstanding entry {addr, client, age} and return to IDLE. If m_ready=0, hold outputs unchanged.
- WR_BURST:
  - Beat 0 drives m_write=1, m_addr, and m_wdata = line[63:0]. Beats 1..3 drive m_write=0, same m_addr, and m_wdata = line[k*64 +: 64].
  - The beat index advances only on edges with m_ready=1; stalls hold the current beat.
  - When the final beat is accepted: c_resp pulses for that client on the next cycle, FSM returns to IDLE.
  - Write response does not wait for DRAM completion; memory ordering is the memory's responsibility.
- Read return:
  - Independent of the issue FSM. A 4-entry x64 assembly buffer fills on m_rvalid; beat k goes to bits [k*64 +: 64].
  - m_raddr is captured on beat 0. Beats arrive back-to-back; m_rvalid dropping mid-burst is an error (assertion), and the counter resets.
  - On beat 3: look up the outstanding entry with addr == m_raddr. If both clients match, the older entry wins.
  - Next cycle: drive c_rdata = assembled line and c_resp = 1 for that client, then clear the entry.
  - No match: assertion error, data dropped.
- A read return and a write completion may respond to different clients in the same cycle. They never target the same client, because each client has only one outstanding request.
- Responses may return out of order relative to issue order.
- Minimum read latency from issue: 1 (grant) + memory latency + 4 beats + 1.

Decomposition:
- Shared package (dram_adapter_pkg):
  - Line-width and beat-count constants.
  - Client-ID typedef.
  - Outstanding-entry struct {valid, addr, age}.
  - Issue FSM enum.
- One natural sub-module: line_deserializer, i.e. beat counter, assembly buffer, raddr capture, and a done pulse.

Test Plan:
- icache read 0x0000_1000, memory returns beats 0x11..,0x22..,0x33..,0x44.. -> m_read high exactly one accepted edge; c_resp[0] pulses once with c_rdata[0] = {0x44..,0x33..,0x22..,0x11..}.
- dcache write 0x0000_2040 with m_ready deasserted after beat 1 for 3 cycles -> m_write only on beat 0, beat 2 held during the stall, 4 distinct beats total, c_resp[1] one cycle after beat 3 is accepted.
- Both clients request in the same cycle after reset -> dcache granted first (pointer starts at 1), icache next; both responses delivered. Returns in reverse order route by m_raddr correctly.
- Both clients read 0x0000_3000, two bursts return -> first burst goes to the first-issued client, second burst to the other.
- rst_n asserted mid write burst (beat 2) -> m_write, m_read, and c_resp go to 0 immediately (asynchronously); after release, a new request is issued cleanly from IDLE.
- dcache read response completing in the same cycle as an icache write burst finishing -> both c_resp bits high together with correct data.
